// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter between two register-bus masters and one slave port.
// It holds a latched copy of the granted access and aborts with an error if the slave never responds.
module reg_bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [7:0]  ERR_RDATA      = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       m0_wr,
   input  logic       m0_rd,
   input  logic [3:0] m0_addr,
   input  logic [7:0] m0_wdata,
   output logic [7:0] m0_rdata,
   output logic       m0_ready,
   output logic       m0_err,
   input  logic       m1_wr,
   input  logic       m1_rd,
   input  logic [3:0] m1_addr,
   input  logic [7:0] m1_wdata,
   output logic [7:0] m1_rdata,
   output logic       m1_ready,
   output logic       m1_err,
   output logic       reg_wr,
   output logic       reg_rd,
   output logic [3:0] reg_addr,
   output logic [7:0] reg_wdata,
   input  logic [7:0] reg_rdata,
   input  logic       reg_ready,
   output logic       busy,
   output logic       owner
);

   // state  | meaning
   // S_IDLE | waiting for a request; arbitrate on the next edge
   // S_BUSY | latched access driven to the slave, waiting for reg_ready or timeout
   // S_DONE | one cycle after completion so the owner can drop its request

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
   logic [3:0]    reg_addr_q, reg_addr_d;
   logic [7:0]    reg_wdata_q, reg_wdata_d;
   logic [7:0]    m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
   logic          m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
   logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;
   logic          busy_q, busy_d, owner_q, owner_d, last_owner_q, last_owner_d;
   logic          req0, req1, gnt, done, timed_out;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      reg_wr_d     = reg_wr_q;
      reg_rd_d     = reg_rd_q;
      reg_addr_d   = reg_addr_q;
      reg_wdata_d  = reg_wdata_q;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      m0_ready_d   = 1'b0;
      m1_ready_d   = 1'b0;
      m0_err_d     = 1'b0;
      m1_err_d     = 1'b0;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      req0         = m0_wr | m0_rd;
      req1         = m1_wr | m1_rd;
      gnt          = (req0 & req1) ? ~last_owner_q : req1;
      done         = 1'b0;
      timed_out    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               // a write wins when both strobes of a requester are high
               reg_wr_d     = gnt ? m1_wr : m0_wr;
               reg_rd_d     = gnt ? (m1_rd & ~m1_wr) : (m0_rd & ~m0_wr);
               reg_addr_d   = gnt ? m1_addr : m0_addr;
               reg_wdata_d  = gnt ? m1_wdata : m0_wdata;
               owner_d      = gnt;
               last_owner_d = gnt;
               cnt_d        = '0;
               state_d      = S_BUSY;
            end
         end
         S_BUSY: begin
            if (reg_ready) begin
               done = 1'b1;
            end else if (TO_EN && (cnt_q == TO_VAL)) begin
               done      = 1'b1;
               timed_out = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            if (done) begin
               reg_wr_d = 1'b0;
               reg_rd_d = 1'b0;
               state_d  = S_DONE;
               if (owner_q) begin
                  m1_ready_d = 1'b1;
                  m1_err_d   = timed_out;
                  if (timed_out)     m1_rdata_d = ERR_RDATA;
                  else if (reg_rd_q) m1_rdata_d = reg_rdata;
               end else begin
                  m0_ready_d = 1'b1;
                  m0_err_d   = timed_out;
                  if (timed_out)     m0_rdata_d = ERR_RDATA;
                  else if (reg_rd_q) m0_rdata_d = reg_rdata;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_BUSY);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         reg_wr_q     <= 1'b0;
         reg_rd_q     <= 1'b0;
         reg_addr_q   <= '0;
         reg_wdata_q  <= '0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
         busy_q       <= 1'b0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         reg_wr_q     <= reg_wr_d;
         reg_rd_q     <= reg_rd_d;
         reg_addr_q   <= reg_addr_d;
         reg_wdata_q  <= reg_wdata_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
         m0_ready_q   <= m0_ready_d;
         m1_ready_q   <= m1_ready_d;
         m0_err_q     <= m0_err_d;
         m1_err_q     <= m1_err_d;
         busy_q       <= busy_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
      end
   end

   assign reg_wr    = reg_wr_q;
   assign reg_rd    = reg_rd_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign m0_ready  = m0_ready_q;
   assign m1_ready  = m1_ready_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter built with a 4-cycle timeout.
module tb_reg_bus_arbiter;

   logic       clk, rst_n;
   logic       m0_wr, m0_rd, m1_wr, m1_rd;
   logic [3:0] m0_addr, m1_addr, reg_addr;
   logic [7:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, reg_wdata, reg_rdata;
   logic       m0_ready, m1_ready, m0_err, m1_err;
   logic       reg_wr, reg_rd, reg_ready, busy, owner;
   int         total, bad;

   reg_bus_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
      .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_ready(reg_ready), .busy(busy), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0;
      m0_wr = 0; m0_rd = 0; m0_addr = 0; m0_wdata = 0;
      m1_wr = 0; m1_rd = 0; m1_addr = 0; m1_wdata = 0;
      reg_rdata = 0; reg_ready = 0;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_strobes", {reg_wr, reg_rd}, 0);
      chk("rst_ready", {m0_ready, m1_ready, m0_err, m1_err}, 0);
      rst_n = 1'b1;
      step();

      // m0 write, slave ready after two wait cycles
      m0_wr = 1; m0_addr = 4'h3; m0_wdata = 8'hA5;
      step();
      chk("wr_e0_busy", busy, 1);
      chk("wr_e0_bus", {reg_wr, reg_rd, reg_addr, reg_wdata}, {1'b1, 1'b0, 4'h3, 8'hA5});
      chk("wr_e0_owner", owner, 0);
      m0_addr = 4'hE; m0_wdata = 8'h00;
      step();
      chk("wr_e1_hold", {reg_wr, reg_addr, reg_wdata, m0_ready}, {1'b1, 4'h3, 8'hA5, 1'b0});
      step();
      chk("wr_e2_hold", {reg_wr, m0_ready}, {1'b1, 1'b0});
      reg_ready = 1;
      step();
      chk("wr_done", {reg_wr, m0_ready, m0_err, m1_ready}, {1'b0, 1'b1, 1'b0, 1'b0});
      chk("wr_rdata_kept", m0_rdata, 8'h00);
      m0_wr = 0; reg_ready = 0;
      step();
      chk("wr_pulse_end", {m0_ready, busy}, 0);

      // m1 read, zero-wait slave; ready already high in IDLE is ignored
      m1_rd = 1; m1_addr = 4'h7; reg_rdata = 8'h3C; reg_ready = 1;
      step();
      chk("rd_e0", {reg_rd, reg_wr, reg_addr, owner, m1_ready}, {1'b1, 1'b0, 4'h7, 1'b1, 1'b0});
      step();
      chk("rd_done", {m1_ready, m1_err, m0_ready, reg_rd}, {1'b1, 1'b0, 1'b0, 1'b0});
      chk("rd_data", m1_rdata, 8'h3C);
      m1_rd = 0; reg_ready = 0; reg_rdata = 8'h00;
      step();
      chk("rd_pulse_end", m1_ready, 0);
      chk("rd_data_hold", m1_rdata, 8'h3C);

      // both request continuously: alternate grants starting with m0
      m0_wr = 1; m0_addr = 4'h1; m0_wdata = 8'h11;
      m1_wr = 1; m1_addr = 4'h2; m1_wdata = 8'h22;
      reg_ready = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_owner", owner, i % 2);
         chk("rr_bus", {busy, reg_wr, reg_rd, reg_addr}, {1'b1, 1'b1, 1'b0, (i % 2) ? 4'h2 : 4'h1});
         step();
         chk("rr_ready", {m0_ready, m1_ready}, (i % 2) ? 2'b01 : 2'b10);
         step();
      end
      m0_wr = 0; m1_wr = 0; reg_ready = 0;
      step();

      // timeout on an m0 read
      m0_rd = 1; m0_addr = 4'h5;
      step();
      chk("to_e0", {reg_rd, owner}, {1'b1, 1'b0});
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("to_wait", {reg_rd, m0_ready, m0_err}, {1'b1, 1'b0, 1'b0});
      end
      step();
      chk("to_abort", {reg_rd, m0_ready, m0_err}, {1'b0, 1'b1, 1'b1});
      chk("to_rdata", m0_rdata, 8'hFF);
      m0_rd = 0;
      step();
      chk("to_pulse_end", {m0_ready, m0_err, busy}, 0);

      // ready in the same cycle the counter hits the limit
      m1_wr = 1; m1_addr = 4'h9; m1_wdata = 8'h11;
      step();
      chk("tie_e0", {reg_wr, owner}, {1'b1, 1'b1});
      for (int i = 1; i <= 4; i++) step();
      reg_ready = 1;
      step();
      chk("tie_done", {m1_ready, m1_err, reg_wr}, {1'b1, 1'b0, 1'b0});
      chk("tie_rdata", m1_rdata, 8'h3C);
      m1_wr = 0; reg_ready = 0;
      step();

      // reset in the middle of an m0 access
      m0_wr = 1; m0_addr = 4'h2; m0_wdata = 8'h77;
      step();
      chk("mr_busy", {busy, owner}, {1'b1, 1'b0});
      rst_n = 0;
      step();
      chk("mr_bus", {reg_wr, reg_rd, reg_addr, reg_wdata, busy, owner}, 0);
      chk("mr_resp", {m0_ready, m1_ready, m0_err, m1_err, m0_rdata, m1_rdata}, 0);
      rst_n = 1;
      m1_wr = 1; m1_addr = 4'hB; m1_wdata = 8'h44;
      step();
      chk("mr_tie_grant", {owner, reg_addr, reg_wdata}, {1'b0, 4'h2, 8'h77});
      reg_ready = 1;
      step();
      chk("mr_done", {m0_ready, m1_ready}, 2'b10);
      m0_wr = 0; m1_wr = 0; reg_ready = 0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
